// File: rtl/booth_mult_arbiter_pkg.sv
// Shared constants and helpers for the Booth multiplier arbiter and its pickers.
package booth_arb_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;
    localparam logic [1:0] RESP  = 2'b11;

    localparam int W_DEF       = 8;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 32;

    // Bits needed to hold values 0..n-1 (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Client request bus plus the multiplier start/done bus seen by the arbiter.
interface booth_mult_arbiter_if #(
    parameter int NREQ = booth_arb_pkg::NREQ_DEF,
    parameter int W    = booth_arb_pkg::W_DEF,
    parameter int IDW  = booth_arb_pkg::clog2(NREQ)
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0][W-1:0] a_in;
    logic [NREQ-1:0][W-1:0] b_in;
    logic [NREQ-1:0]        grant;
    logic                   mult_start;
    logic [W-1:0]           mult_a;
    logic [W-1:0]           mult_b;
    logic                   mult_done;
    logic [2*W-1:0]         mult_product;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [2*W-1:0]         result;
    logic                   res_err;
    logic                   busy;

    modport slave (
        input  req, a_in, b_in, mult_done, mult_product,
        output grant, mult_start, mult_a, mult_b, res_valid, res_id, result, res_err, busy
    );

    modport master (
        output req, a_in, b_in, mult_done, mult_product,
        input  grant, mult_start, mult_a, mult_b, res_valid, res_id, result, res_err, busy
    );
endinterface

// File: rtl/booth_mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_picker
    import booth_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);
    logic [NREQ-1:0][IDW-1:0] cand;
    logic [NREQ:0][IDW-1:0]   sel;

    assign sel[NREQ] = rr_ptr;

    // Candidate k is the k-th client after rr_ptr; lowest k with a request wins.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand[k] = IDW'((int'(rr_ptr) + k) % NREQ);
        assign sel[k]  = req[cand[k]] ? cand[k] : sel[k+1];
    end

    assign winner  = sel[0];
    assign any_req = |req;
endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one start/done multiplier among NREQ clients.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    booth_mult_arbiter_if.slave bus
);
    localparam int IDW = clog2(NREQ);
    localparam int WDW = clog2(TIMEOUT);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic [WDW-1:0] wdog;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wdog           <= '0;
            bus.grant      <= '0;
            bus.mult_start <= 1'b0;
            bus.mult_a     <= '0;
            bus.mult_b     <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_id     <= '0;
            bus.result     <= '0;
            bus.res_err    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.grant      <= '0;
            bus.mult_start <= 1'b0;
            bus.res_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.mult_a     <= bus.a_in[winner];
                        bus.mult_b     <= bus.b_in[winner];
                        bus.res_id     <= winner;
                        bus.grant      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                        bus.mult_start <= 1'b1;
                        bus.busy       <= 1'b1;
                        wdog           <= '0;
                        state          <= ISSUE;
                    end
                end
                // wdog counts cycles since the start pulse, so WAIT lasts at most TIMEOUT-1 cycles.
                ISSUE: begin
                    wdog  <= wdog + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (bus.mult_done) begin
                        bus.result    <= bus.mult_product;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= RESP;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        bus.result    <= '0;
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr      <= (bus.res_id == IDW'(NREQ - 1)) ? '0 : bus.res_id + 1'b1;
                    bus.res_err <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one Booth multiplier datapath, with its sequencing controller, among NREQ independent requesters. Uses a round-robin scheme to pick a requester and latches that requester's operands. Issues a one-cycle start to the multiplier, waits for done (bounded by a watchdog), then returns the product tagged with the requester ID. Sits between the client blocks and the multiplier's start/done interface.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width (two's complement); product is 2W bits
TIMEOUT, 32, max cycles in WAIT before an error response (>=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req  in  NREQ  request per client; held high until its grant
a_in  in  NREQ*W  multiplicand per client, slice i = client i
b_in  in  NREQ*W  multiplier per client, slice i = client i
grant  out  NREQ  one-hot, one-cycle pulse: operands accepted
mult_start  out  1  one-cycle start pulse to the multiplier
mult_a  out  W  latched multiplicand to the multiplier
mult_b  out  W  latched multiplier to the multiplier
mult_done  in  1  multiplier completion flag
mult_product  in  2W  multiplier result, valid when mult_done=1
res_valid  out  1  one-cycle result strobe
res_id  out  clog2(NREQ)  client the result belongs to
result  out  2W  signed product
res_err  out  1  1 with res_valid = watchdog expired, result=0
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, rr_ptr=0, and all outputs 0 (grant, mult_start, mult_a, mult_b, res_valid, res_id, result, res_err, busy). Reset overrides everything, including mid-WAIT. A mult_done that arrives after reset is ignored.
- All outputs are registered.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, when any req bit is 1:
  - winner = first set bit, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NREQ.
  - Latch a_in/b_in slices of the winner into mult_a/mult_b and latch the winner into res_id.
  - Next state ISSUE.
  - With no req, stay in IDLE.
- ISSUE (exactly one cycle): grant[winner]=1 and mult_start=1. Clear wdog. Next state WAIT.
- WAIT:
  - wdog increments each cycle.
  - If mult_done=1: capture mult_product into result, res_err=0, go to RESP.
  - Else if wdog==TIMEOUT-1: result=0, res_err=1, go to RESP.
  - If mult_done and timeout occur in the same cycle, done wins.
- RESP (exactly one cycle): res_valid=1. rr_ptr = (res_id+1) mod NREQ. Next state IDLE.
- mult_a/mult_b stay stable from ISSUE through RESP. They change only on the next IDLE acceptance.
- mult_done outside WAIT (spurious) is ignored, with no state change.
- req bits are sampled only in IDLE. Changes during ISSUE, WAIT or RESP have no effect.
- A client that drops req before it is granted simply loses its turn; no error is raised.
- Minimum latency: req high at edge k gives grant and mult_start in cycle k+1. If the multiplier takes L cycles from start to done, res_valid is high in cycle k+L+2.
- Throughput: one operation in flight at a time; the next acceptance is the cycle after RESP.
- result is the sign-correct 2W product as supplied by the multiplier; no truncation.

Decomposition:
- Package booth_arb_pkg holds:
  - state encoding localparams IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11;
  - ID width function clog2;
  - default W/NREQ/TIMEOUT constants.
- Sub-module rr_picker: combinational, with inputs req[NREQ] and rr_ptr, and outputs winner id plus any_req. It is reused by the future register-file port arbiter.

Test Plan:
- W=8, NREQ=4; client 2 requests with a=3, b=-4; model multiplier has L=9. Expect grant=4'b0100 and mult_start in the cycle after req, and res_valid 11 cycles after req with res_id=2, result=16'hFFF4, res_err=0.
- req=4'b1111 held continuously after reset. Expect grants in order 0,1,2,3,0. Each res_id matches its grant, and no client is granted twice before the others.
- Client 1 is served, then req=4'b0011. Expect client 0 granted next (rr_ptr=2 wraps to 0), then client 1.
- TIMEOUT=16 with a model that never asserts done. Expect res_valid with res_err=1 and result=0 exactly 16 cycles after ISSUE; busy=0 on the next cycle.
- reset=0 for one cycle during WAIT, followed by a late mult_done. Expect all outputs 0, state IDLE and no res_valid. A new req=4'b0001 is then granted to client 0.
- mult_done pulse while in IDLE, and mult_done coinciding with the timeout cycle. Expect the IDLE pulse to be ignored, and the coincident case to give res_err=0 with the captured product.
